// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
//   loader_state_t  : FSM state encoding (3 bits)
//   LEN_BYTES       : bytes in the little-endian word-count header
//   BYTES_PER_WORD  : stream bytes per assembled instruction word
//   byte_addr()     : word index -> word-aligned byte address
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN0  = 3'd1,
        ST_LEN1  = 3'd2,
        ST_DATA  = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } loader_state_t;

    localparam int LEN_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int CNT_W          = LEN_BYTES * 8;

    function automatic logic [CNT_W+1:0] byte_addr(input logic [CNT_W-1:0] idx);
        return {idx, 2'b00};
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Host-side bundle of the loader: load request, byte stream handshake,
// instruction-memory write port and core/status outputs.
//   master : boot host / testbench (drives start, rxData, rxValid)
//   slave  : imem_loader
interface imem_loader_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              start;
    logic [7:0]        rxData;
    logic              rxValid;
    logic              rxReady;
    logic              wrEn;
    logic [ADDR_W-1:0] wrAddr;
    logic [DATA_W-1:0] wrData;
    logic              coreHold;
    logic              done;
    logic              err;

    modport master (
        output start, rxData, rxValid,
        input  rxReady, wrEn, wrAddr, wrData, coreHold, done, err
    );

    modport slave (
        input  start, rxData, rxValid,
        output rxReady, wrEn, wrAddr, wrData, coreHold, done, err
    );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// 8 -> 32 bit little-endian word assembler.
//   clk, rst        : clock, async active-high reset
//   clear_i         : drop any partial word and restart at byte 0
//   byte_i/valid_i  : accepted stream byte
//   word_o          : assembled word, valid together with word_valid_o
//   word_valid_o    : combinational pulse on the fourth byte of a word
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic [7:0]  byte_i,
    input  logic        byte_valid_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  cnt_q;
    logic [23:0] shift_q;

    // Bytes shift in from the top, so after three bytes shift_q = {b2, b1, b0}
    // and the fourth byte completes {b3, b2, b1, b0} without storing it.
    assign word_o       = {byte_i, shift_q};
    assign word_valid_o = byte_valid_i && (cnt_q == LAST_BYTE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else if (clear_i) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else if (byte_valid_i) begin
            cnt_q   <= cnt_q + 2'd1;
            shift_q <= {byte_i, shift_q[23:8]};
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader. Receives a 16-bit LE word count and
// then that many 32-bit LE words, writing each to consecutive word-aligned
// addresses while holding the core in reset.
//   clk, rst : clock, async active-high reset
//   bus      : imem_loader_if slave (start, rx stream, write port, status)
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   IDLE     | after reset, waiting for start
//   LEN0     | expecting count[7:0]
//   LEN1     | expecting count[15:8]; decides DONE / ERROR / DATA
//   DATA     | assembling and writing words
//   DONE     | load complete; core released, start re-arms
//   ERROR    | count exceeded capacity; core held, start re-arms
module imem_loader
    import loader_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 512
) (
    input  logic          clk,
    input  logic          rst,
    imem_loader_if.slave  bus
);

    localparam logic [2:0] S_IDLE  = ST_IDLE;
    localparam logic [2:0] S_LEN0  = ST_LEN0;
    localparam logic [2:0] S_LEN1  = ST_LEN1;
    localparam logic [2:0] S_DATA  = ST_DATA;
    localparam logic [2:0] S_DONE  = ST_DONE;
    localparam logic [2:0] S_ERROR = ST_ERROR;

    localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(DEPTH);

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              hold_q, hold_d;

    logic              rx_ready;
    logic              accept;
    logic              start_ok;
    logic [CNT_W-1:0]  len_n;
    logic [CNT_W-1:0]  idx_next;
    logic [31:0]       pk_word;
    logic              pk_word_valid;

    assign rx_ready = (state_q == S_LEN0) || (state_q == S_LEN1) || (state_q == S_DATA);
    assign accept   = bus.rxValid && rx_ready;
    assign start_ok = bus.start &&
                      ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR));
    assign len_n    = {bus.rxData, count_q[7:0]};
    assign idx_next = idx_q + 1'b1;

    byte_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (start_ok),
        .byte_i       (bus.rxData),
        .byte_valid_i (accept && (state_q == S_DATA)),
        .word_o       (pk_word),
        .word_valid_o (pk_word_valid)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        idx_d     = idx_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = done_q;
        err_d     = err_q;
        hold_d    = hold_q;

        case (state_q)
            S_IDLE, S_ERROR: begin
                if (start_ok) begin
                    state_d = S_LEN0;
                    idx_d   = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    hold_d  = 1'b1;
                end
            end
            S_LEN0: begin
                if (accept) begin
                    count_d = {{(CNT_W-8){1'b0}}, bus.rxData};
                    state_d = S_LEN1;
                end
            end
            S_LEN1: begin
                if (accept) begin
                    count_d = len_n;
                    if (len_n == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else if ({1'b0, len_n} > DEPTH_L) begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (pk_word_valid) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = DATA_W'(pk_word);
                    wr_addr_d = ADDR_W'(byte_addr(idx_q));
                    idx_d     = idx_next;
                    if (idx_next == count_q) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // Entering DONE from DATA leaves done/hold untouched for one
                // cycle, so done never rises alongside the final write strobe.
                if (start_ok) begin
                    state_d = S_LEN0;
                    idx_d   = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    hold_d  = 1'b1;
                end else begin
                    done_d  = 1'b1;
                    hold_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            idx_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            hold_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            idx_q     <= idx_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            err_q     <= err_d;
            hold_q    <= hold_d;
        end
    end

    assign bus.rxReady  = rx_ready;
    assign bus.wrEn     = wr_en_q;
    assign bus.wrAddr   = wr_addr_q;
    assign bus.wrData   = wr_data_q;
    assign bus.coreHold = hold_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    localparam int DEPTH = 512;

    typedef logic [7:0] bytes_t[$];

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    imem_loader_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    imem_loader #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];

    always @(negedge clk) begin
        if (bus.wrEn === 1'b1) begin
            obs_addr.push_back(bus.wrAddr);
            obs_data.push_back(bus.wrData);
            check("done_low_during_wr", 64'(bus.done), 64'd0);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        check("hold_at_start", 64'(bus.coreHold), 64'd1);
        check("done_cleared", 64'(bus.done), 64'd0);
        check("err_cleared", 64'(bus.err), 64'd0);
        bus.start = 1'b0;
        @(negedge clk);
        check("ready_after_start", 64'(bus.rxReady), 64'd1);
    endtask

    // Returns right after the edge that took the last byte; rxValid stays high.
    task automatic send(input bytes_t b, input int max_gap, input int start_at);
        logic rdy;
        int   tries;
        for (int i = 0; i < b.size(); i++) begin
            if (i == start_at) begin
                @(negedge clk);
                bus.rxValid = 1'b0;
                bus.start   = 1'b1;
                @(negedge clk);
                bus.start   = 1'b0;
            end
            if (max_gap > 0) begin
                repeat ($urandom_range(max_gap, 0)) begin
                    @(negedge clk);
                    bus.rxValid = 1'b0;
                    bus.rxData  = 8'($urandom);
                end
            end
            tries = 0;
            forever begin
                @(negedge clk);
                bus.rxValid = 1'b1;
                bus.rxData  = b[i];
                rdy = bus.rxReady;
                @(posedge clk);
                if (rdy) break;
                tries++;
                if (tries > 50) begin
                    check("ready_timeout", 64'd0, 64'd1);
                    return;
                end
            end
        end
    endtask

    task automatic run_load(input bytes_t b, input int max_gap, input int start_at, input string nm);
        int          n;
        logic [31:0] exp_addr[$];
        logic [31:0] exp_data[$];

        n = int'(b[0]) + 256 * int'(b[1]);
        if (n >= 1 && n <= DEPTH) begin
            for (int w = 0; w < n; w++) begin
                exp_addr.push_back(32'(4 * w));
                exp_data.push_back({b[2 + 4*w + 3], b[2 + 4*w + 2], b[2 + 4*w + 1], b[2 + 4*w]});
            end
        end

        obs_addr.delete();
        obs_data.delete();
        do_start();
        send(b, max_gap, start_at);
        @(negedge clk);
        bus.rxValid = 1'b0;

        if (n == 0) begin
            check({nm, "_done"}, 64'(bus.done), 64'd1);
            check({nm, "_hold"}, 64'(bus.coreHold), 64'd0);
            check({nm, "_err"}, 64'(bus.err), 64'd0);
            check({nm, "_ready"}, 64'(bus.rxReady), 64'd0);
        end else if (n > DEPTH) begin
            check({nm, "_err"}, 64'(bus.err), 64'd1);
            check({nm, "_hold"}, 64'(bus.coreHold), 64'd1);
            check({nm, "_ready"}, 64'(bus.rxReady), 64'd0);
            check({nm, "_done"}, 64'(bus.done), 64'd0);
            repeat (3) @(negedge clk);
            check({nm, "_err_sticky"}, 64'(bus.err), 64'd1);
        end else begin
            check({nm, "_last_wr"}, 64'(bus.wrEn), 64'd1);
            check({nm, "_done_early"}, 64'(bus.done), 64'd0);
            check({nm, "_hold_last_wr"}, 64'(bus.coreHold), 64'd1);
            @(negedge clk);
            check({nm, "_done"}, 64'(bus.done), 64'd1);
            check({nm, "_hold"}, 64'(bus.coreHold), 64'd0);
            check({nm, "_wren_off"}, 64'(bus.wrEn), 64'd0);
            check({nm, "_ready"}, 64'(bus.rxReady), 64'd0);
        end

        repeat (2) @(negedge clk);
        check({nm, "_nwrites"}, 64'(obs_addr.size()), 64'(exp_addr.size()));
        for (int k = 0; k < exp_addr.size() && k < obs_addr.size(); k++) begin
            check($sformatf("%s_addr%0d", nm, k), 64'(obs_addr[k]), 64'(exp_addr[k]));
            check($sformatf("%s_data%0d", nm, k), 64'(obs_data[k]), 64'(exp_data[k]));
        end
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_ready"}, 64'(bus.rxReady), 64'd0);
        check({nm, "_wren"}, 64'(bus.wrEn), 64'd0);
        check({nm, "_hold"}, 64'(bus.coreHold), 64'd0);
        check({nm, "_done"}, 64'(bus.done), 64'd0);
        check({nm, "_err"}, 64'(bus.err), 64'd0);
        check({nm, "_addr"}, 64'(bus.wrAddr), 64'd0);
        check({nm, "_data"}, 64'(bus.wrData), 64'd0);
    endtask

    bytes_t basic;
    bytes_t stream;

    initial begin
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.rxValid = 1'b0;
        bus.rxData  = 8'h00;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check_all_zero("idle");
        check("idle_nwrites", 64'(obs_addr.size()), 64'd0);

        basic = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        run_load(basic, 0, -1, "two_words");

        stream = '{8'h00, 8'h00};
        run_load(stream, 0, -1, "zero_len");

        stream = '{8'h01, 8'h02};
        run_load(stream, 0, -1, "over_cap");
        stream = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_load(stream, 0, -1, "after_err");
        check("after_err_errflag", 64'(bus.err), 64'd0);

        run_load(basic, 5, 4, "gaps_start");

        // Reset after two data bytes of word 0: partial word must vanish.
        obs_addr.delete();
        obs_data.delete();
        do_start();
        stream = '{8'h01, 8'h00, 8'hAA, 8'hBB};
        send(stream, 0, -1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("midload_rst");
        bus.rxValid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("midload_nwrites", 64'(obs_addr.size()), 64'd0);
        stream = '{8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
        run_load(stream, 0, -1, "post_rst");

        // Exactly at capacity: last address 0x7FC.
        stream = '{8'h00, 8'h02};
        for (int i = 0; i < 4 * DEPTH; i++) stream.push_back(8'($urandom));
        run_load(stream, 0, -1, "full_depth");

        stream = '{8'h01, 8'h02};
        stream[0] = 8'h00;
        stream[1] = 8'h02;
        stream.delete();
        stream = '{8'h01, 8'h02};
        stream[1] = 8'h02;
        stream[0] = 8'h01;

        for (int it = 0; it < 8; it++) begin
            int n;
            int kind;
            int sa;
            kind = int'($urandom_range(9, 0));
            if (kind == 0) n = 0;
            else if (kind == 1) n = DEPTH + 1 + int'($urandom_range(2000, 0));
            else n = int'($urandom_range(6, 1));
            stream.delete();
            stream.push_back(8'(n));
            stream.push_back(8'(n >> 8));
            if (n >= 1 && n <= DEPTH) begin
                for (int i = 0; i < 4 * n; i++) stream.push_back(8'($urandom));
                sa = ($urandom_range(1, 0) == 1) ? int'($urandom_range(4 * n + 1, 2)) : -1;
            end else begin
                sa = -1;
            end
            run_load(stream, int'($urandom_range(3, 0)), sa, $sformatf("rnd%0d", it));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
